// File: rtl/wb_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter with bus-cycle locking.
// Tracks outstanding transfers per grant and returns ack/data only to the owner.
//   state | meaning
//   IDLE  | no owner, arbitrate among requesters at the next edge
//   OWN0  | master 0 owns the bus cycle
//   OWN1  | master 1 owns the bus cycle
module wb_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wbm0_cyc,
  input  logic        i_wbm0_stb,
  input  logic        i_wbm0_we,
  input  logic [15:0] i_wbm0_adr,
  input  logic [15:0] i_wbm0_dat,
  output logic        o_wbm0_stall,
  output logic        o_wbm0_ack,
  output logic [15:0] o_wbm0_dat,
  input  logic        i_wbm1_cyc,
  input  logic        i_wbm1_stb,
  input  logic        i_wbm1_we,
  input  logic [15:0] i_wbm1_adr,
  input  logic [15:0] i_wbm1_dat,
  output logic        o_wbm1_stall,
  output logic        o_wbm1_ack,
  output logic [15:0] o_wbm1_dat,
  output logic        o_wbs_cyc,
  output logic        o_wbs_stb,
  output logic        o_wbs_we,
  output logic [15:0] o_wbs_adr,
  output logic [15:0] o_wbs_dat,
  input  logic        i_wbs_stall,
  input  logic        i_wbs_ack,
  input  logic [15:0] i_wbs_dat,
  output logic [1:0]  o_gnt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_last, w_last_next;

  logic        w_sel0, w_sel1, w_own_cyc, w_own_stb, w_active, w_full, w_accept;

  assign w_sel0    = (r_state == OWN0);
  assign w_sel1    = (r_state == OWN1);
  assign w_own_cyc = (w_sel0 & i_wbm0_cyc) | (w_sel1 & i_wbm1_cyc);
  assign w_own_stb = (w_sel0 & i_wbm0_stb) | (w_sel1 & i_wbm1_stb);
  assign w_active  = w_own_cyc;
  assign w_full    = (r_cnt == 4'(MAX_OUT));

  // Slave side follows the owner only while it still holds cyc (abort drops it at once).
  assign o_wbs_cyc = w_active;
  assign o_wbs_stb = w_active & w_own_stb & ~w_full;
  assign o_wbs_we  = w_active & (w_sel1 ? i_wbm1_we : i_wbm0_we);
  assign o_wbs_adr = w_active ? (w_sel1 ? i_wbm1_adr : i_wbm0_adr) : 16'h0000;
  assign o_wbs_dat = w_active ? (w_sel1 ? i_wbm1_dat : i_wbm0_dat) : 16'h0000;
  assign w_accept  = o_wbs_stb & ~i_wbs_stall;

  assign o_wbm0_stall = ~w_sel0 | i_wbs_stall | w_full;
  assign o_wbm1_stall = ~w_sel1 | i_wbs_stall | w_full;
  assign o_wbm0_ack   = w_sel0 & i_wbm0_cyc & i_wbs_ack;
  assign o_wbm1_ack   = w_sel1 & i_wbm1_cyc & i_wbs_ack;
  assign o_wbm0_dat   = w_sel0 ? i_wbs_dat : 16'h0000;
  assign o_wbm1_dat   = w_sel1 ? i_wbs_dat : 16'h0000;
  assign o_gnt        = {w_sel1, w_sel0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = 4'd0;
        if (i_wbm0_cyc && i_wbm1_cyc) begin
          // Round-robin favours whoever did not own the bus last.
          if (FIXED_PRIO || r_last) w_state_next = OWN0;
          else                      w_state_next = OWN1;
        end else if (i_wbm0_cyc) begin
          w_state_next = OWN0;
        end else if (i_wbm1_cyc) begin
          w_state_next = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!w_active) begin
          w_state_next = IDLE;
          w_last_next  = w_sel1;
          w_cnt_next   = 4'd0;
        end else begin
          case ({w_accept, i_wbs_ack && (r_cnt != 4'd0)})
            2'b10:   w_cnt_next = r_cnt + 4'd1;
            2'b01:   w_cnt_next = r_cnt - 4'd1;
            default: w_cnt_next = r_cnt;
          endcase
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master to one-slave pipelined Wishbone arbiter (16-bit address, 16-bit data).
- Lets the J1 CPU (m0) and a second bus master (m1: DMA/debug loader) share the wb_intercon master port.
- Grants whole bus cycles (cyc-level locking), tracks outstanding pipelined transfers, and routes ack and read data back only to the owning master.

Parameters:
- MAX_OUT, 4, maximum accepted-but-unacknowledged transfers per grant (1..15).
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- wbm0  if_wb.slave  bundle  master 0 (CPU): cyc, stb, we, adr[15:0], dat_m[15:0] in; stall, ack, dat_s[15:0] out
- wbm1  if_wb.slave  bundle  master 1 (DMA/debug), same signal set as wbm0
- wbs  if_wb.master  bundle  shared slave side toward wb_intercon: cyc, stb, we, adr, dat_m out; stall, ack, dat_s in
- gnt  output  2  one-hot owner indication {m1,m0}; 2'b00 = bus idle

Behaviour:
- States: IDLE, OWN0, OWN1. Reset (async, rst=1) forces IDLE, gnt=00, outstanding count=0, last_owner=m1 (so m0 wins first round-robin tie).
- Outputs during reset and in IDLE: wbs.cyc=0, wbs.stb=0, wbm0/1.ack=0, wbm0/1.stall=1, dat_s=0.
- IDLE -> OWNx is registered: a request (cyc=1) at edge N gives ownership from cycle N+1. This is one cycle of arbitration latency; the requester sees stall=1 during cycle N.
- Simultaneous requests:
  - FIXED_PRIO=1: m0 wins.
  - FIXED_PRIO=0: the master that was not last_owner wins.
- Owner path while OWNx: wbs.cyc/stb/we/adr/dat_m = owner's signals (combinational mux); owner.stall = wbs.stall | (cnt==MAX_OUT); owner.ack = wbs.ack; owner.dat_s = wbs.dat_s.
- Non-owner: stall=1, ack=0, dat_s=0.
- Outstanding counter cnt (4 bits):
  - +1 on accept (wbs.stb & !owner.stall), -1 on wbs.ack; both in one cycle leaves it unchanged.
  - When cnt==MAX_OUT, wbs.stb is forced 0 and the owner is stalled.
  - An ack with cnt==0 is passed through; cnt saturates at 0 (no underflow).
- Release: owner drops cyc -> wbs.cyc drops in the same cycle (Wishbone abort semantics). cnt is cleared, late acks are discarded, and the state returns to IDLE at the next edge with last_owner updated.
- Back-to-back: in the cycle after release, IDLE re-arbitrates, so the other master waiting is granted one edge later. There is a minimum 1 idle cycle between ownerships; no grant change ever occurs while cyc is held.
- Starvation bound (FIXED_PRIO=0): a continuously requesting master is granted within one full cycle of the other master.
- Owner holding cyc indefinitely is legal; no timeout in this block.
- Async reset mid-transfer: wbs.cyc/stb drop immediately and all acks are suppressed; slaves must tolerate the abort.

Test Plan:
- Reset: assert rst mid-stream -> gnt=00, wbs.cyc=0, both stalls=1 within the same cycle; first m0 request after release -> gnt=01 one edge later.
- Single m0 read burst: m0 issues 3 pipelined reads to 0x4000..0x4002, slave acks with 1-cycle latency -> m0 receives 3 acks with correct dat_s; m1 sees ack=0 throughout; cnt returns to 0.
- Outstanding limit: MAX_OUT=2, slave withholds ack for 5 cycles while m0 keeps stb=1 -> exactly 2 accepts, then owner.stall=1 and wbs.stb=0 until the first ack arrives.
- Contention, round-robin: m0 and m1 both request continuously with FIXED_PRIO=0 -> grant order m0, m1, m0, m1 with one idle cycle between; each cycle completes before the switch.
- Fixed priority: FIXED_PRIO=1, both request at the same edge -> m0 granted; m1 granted only after m0 drops cyc and m0 is not requesting at the re-arbitration edge.
- Abort: m1 drops cyc with cnt=2 -> wbs.cyc=0 in the same cycle; a subsequent slave ack is not forwarded to either master; state is IDLE at the next edge.
